ahb_lite_fir_slave_gen: RTL and testbench

Parametrised AHB-Lite slave for the FIR filter accelerator. It supports N coefficient registers, a sample FIFO that decouples bus writes from filter consumption, byte and halfword access, and error responses for illegal accesses. It sits between the AHB-Lite bus and the FIR filter / coefficient loader, and supersedes the fixed 4-coefficient, single-sample slave.

---
 rtl/ahb_lite_fir_slave_gen.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ahb_lite_fir_slave_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_fir_slave_gen.sv
// ---------------------------------------------------------------------------
// ahb_lite_fir_slave_gen
//
// AHB-Lite slave front end for the FIR filter accelerator. Holds NUM_COEFF
// coefficient registers, a FIFO_DEPTH-entry sample FIFO that the filter pops
// through a lock-protected handshake, and a coefficient-reload flag. Supports
// byte and halfword accesses and returns a single-cycle error response for
// illegal accesses without changing any state.
//
// Ports
//   clk, n_rst            : clock, asynchronous active-low reset
//   hsel, htrans, haddr,
//   hsize, hwrite, hwdata : AHB-Lite address/data phase inputs
//   hrdata, hresp         : data-phase read data and error response
//   fir_out, modwait, err : filter result, busy and error status
//   coefficient_num       : coefficient index requested by the loader
//   coeff_clr             : loader done, clears new_coefficient_set
//   sample_data           : FIFO head (0 when empty)
//   data_ready            : sample available to the filter
//   fir_coefficient       : coeff[coefficient_num] (0 when out of range)
//   new_coefficient_set   : coefficient reload request
//
// Register map (byte addresses, halfword aligned)
//   0x00 STATUS  RO  {7'b0, err, 6'b0, fifo_full, modwait | !fifo_empty}
//   0x02 RESULT  RO  fir_out
//   0x04 SAMPLE  W: push, R: FIFO head or 0
//   0x06 COEFF_SET RW flag
//   0x08 FIFO_COUNT RO occupancy
//   0x10+2k COEFF k RW
// ---------------------------------------------------------------------------
module ahb_lite_fir_slave_gen #(
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 5,
    localparam int CW        = $clog2(NUM_COEFF)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  hsel,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hsize,
    input  logic                  hwrite,
    input  logic [15:0]           hwdata,
    output logic [15:0]           hrdata,
    output logic                  hresp,
    input  logic [15:0]           fir_out,
    input  logic                  modwait,
    input  logic                  err,
    input  logic [CW-1:0]         coefficient_num,
    input  logic                  coeff_clr,
    output logic [15:0]           sample_data,
    output logic                  data_ready,
    output logic [15:0]           fir_coefficient,
    output logic                  new_coefficient_set
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    // Halfword indices of the mapped registers
    localparam logic [ADDR_WIDTH-1:0] HI_STATUS  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] HI_RESULT  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] HI_SAMPLE  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] HI_CSET    = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] HI_COUNT   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] HI_COEFF0  = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] HI_COEFFN  = ADDR_WIDTH'(8 + NUM_COEFF);

    // Replace the addressed byte lane of a register, or the whole value for
    // a halfword access. The master drives byte data on the lane matching
    // haddr[0], so no shifting is required.
    function automatic logic [15:0] f_merge(input logic [15:0] old_val,
                                            input logic        size_hw,
                                            input logic        lane_hi,
                                            input logic [15:0] wdata);
        logic [15:0] v;
        v = old_val;
        if (size_hw) begin
            v = wdata;
        end else if (lane_hi) begin
            v[15:8] = wdata[15:8];
        end else begin
            v[7:0] = wdata[7:0];
        end
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // Address phase capture
    // -----------------------------------------------------------------------
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_size;
    logic                  r_write;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_size  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_valid <= hsel & htrans[1];
            if (hsel & htrans[1]) begin
                r_addr  <= haddr;
                r_size  <= hsize;
                r_write <= hwrite;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data phase decode
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_hidx;
    logic                  w_sel_status;
    logic                  w_sel_result;
    logic                  w_sel_sample;
    logic                  w_sel_cset;
    logic                  w_sel_count;
    logic                  w_sel_coeff;
    logic                  w_mapped;
    logic [CW-1:0]         w_cidx;
    logic                  w_err_cond;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign w_hidx       = {1'b0, r_addr[ADDR_WIDTH-1:1]};
    assign w_sel_status = (w_hidx == HI_STATUS);
    assign w_sel_result = (w_hidx == HI_RESULT);
    assign w_sel_sample = (w_hidx == HI_SAMPLE);
    assign w_sel_cset   = (w_hidx == HI_CSET);
    assign w_sel_count  = (w_hidx == HI_COUNT);
    assign w_sel_coeff  = (w_hidx >= HI_COEFF0) && (w_hidx < HI_COEFFN);
    assign w_mapped     = w_sel_status | w_sel_result | w_sel_sample |
                          w_sel_cset | w_sel_count | w_sel_coeff;
    assign w_cidx       = CW'(w_hidx - HI_COEFF0);

    // FIFO state needed by the error check
    logic [CNTW-1:0] r_count;
    logic            r_pop_lock;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_pop;
    logic            w_push;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNTW'(FIFO_DEPTH));
    assign data_ready   = ~w_fifo_empty & ~r_pop_lock;
    assign w_pop        = data_ready & modwait;

    // A push to a full FIFO is legal only when a pop frees a slot at the
    // same edge.
    assign w_err_cond = ~w_mapped
                      | (r_write & (w_sel_status | w_sel_result | w_sel_count))
                      | (r_size & r_addr[0])
                      | (r_write & w_sel_sample & ~r_size)
                      | (r_write & w_sel_sample & w_fifo_full & ~w_pop);

    assign w_wr_ok = r_valid &  r_write & ~w_err_cond;
    assign w_rd_ok = r_valid & ~r_write & ~w_err_cond;
    assign w_push  = w_wr_ok & w_sel_sample;
    assign hresp   = r_valid & w_err_cond;

    // -----------------------------------------------------------------------
    // Coefficient registers
    // -----------------------------------------------------------------------
    logic [15:0] r_coeff [NUM_COEFF];
    logic [15:0] w_coeff_pad [1 << CW];

    generate
        for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_coeff
            logic w_we;
            assign w_we = w_wr_ok & w_sel_coeff & (w_cidx == CW'(gi));

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_coeff[gi] <= '0;
                end else if (w_we) begin
                    r_coeff[gi] <= f_merge(r_coeff[gi], r_size, r_addr[0], hwdata);
                end
            end
        end

        // Pad to a power-of-two table so any coefficient_num indexes safely;
        // indices beyond NUM_COEFF read as zero.
        for (genvar gi = 0; gi < (1 << CW); gi++) begin : g_pad
            if (gi < NUM_COEFF) begin : g_real
                assign w_coeff_pad[gi] = r_coeff[gi];
            end else begin : g_zero
                assign w_coeff_pad[gi] = '0;
            end
        end
    endgenerate

    assign fir_coefficient = w_coeff_pad[coefficient_num];

    // -----------------------------------------------------------------------
    // Coefficient reload flag
    // -----------------------------------------------------------------------
    logic        r_ncs;
    logic [15:0] w_cset_merged;

    assign w_cset_merged = f_merge({15'b0, r_ncs}, r_size, r_addr[0], hwdata);

    // A bus write takes priority over the loader's clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ncs <= 1'b0;
        end else if (w_wr_ok & w_sel_cset) begin
            r_ncs <= |w_cset_merged;
        end else if (coeff_clr) begin
            r_ncs <= 1'b0;
        end
    end

    assign new_coefficient_set = r_ncs;

    // -----------------------------------------------------------------------
    // Sample FIFO
    // -----------------------------------------------------------------------
    logic [15:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [15:0]   w_fifo_head;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_fifo_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_fifo_mem[gi] <= hwdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_lock <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Lock holds off further pops until the filter drops modwait,
            // so one busy period consumes exactly one sample.
            if (w_pop) begin
                r_pop_lock <= 1'b1;
            end else if (!modwait) begin
                r_pop_lock <= 1'b0;
            end
        end
    end

    assign w_fifo_head = r_fifo_mem[r_rd_ptr];
    assign sample_data = w_fifo_empty ? 16'h0000 : w_fifo_head;

    // -----------------------------------------------------------------------
    // Read data mux. Writes commit at the edge ending their data phase, so a
    // read in the following data phase already sees the new register value.
    // -----------------------------------------------------------------------
    logic [15:0] w_rdata;

    always_comb begin
        w_rdata = 16'h0000;
        if (w_sel_status) begin
            w_rdata = {7'b0, err, 6'b0, w_fifo_full, modwait | ~w_fifo_empty};
        end else if (w_sel_result) begin
            w_rdata = fir_out;
        end else if (w_sel_sample) begin
            w_rdata = sample_data;
        end else if (w_sel_cset) begin
            w_rdata = {15'b0, r_ncs};
        end else if (w_sel_count) begin
            w_rdata = 16'(r_count);
        end else if (w_sel_coeff) begin
            w_rdata = w_coeff_pad[w_cidx];
        end
    end

    assign hrdata = w_rd_ok ? w_rdata : 16'h0000;

endmodule

// File: tb/tb_ahb_lite_fir_slave_gen.sv
module tb_ahb_lite_fir_slave_gen;

    logic        clk;
    logic        n_rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic [4:0]  haddr;
    logic        hsize;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;
    logic [15:0] fir_out;
    logic        modwait;
    logic        err;
    logic [1:0]  coefficient_num;
    logic        coeff_clr;
    logic [15:0] sample_data;
    logic        data_ready;
    logic [15:0] fir_coefficient;
    logic        new_coefficient_set;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rd;
    logic        rs;

    ahb_lite_fir_slave_gen #(
        .NUM_COEFF (4),
        .FIFO_DEPTH(4),
        .ADDR_WIDTH(5)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .hsel               (hsel),
        .htrans             (htrans),
        .haddr              (haddr),
        .hsize              (hsize),
        .hwrite             (hwrite),
        .hwdata             (hwdata),
        .hrdata             (hrdata),
        .hresp              (hresp),
        .fir_out            (fir_out),
        .modwait            (modwait),
        .err                (err),
        .coefficient_num    (coefficient_num),
        .coeff_clr          (coeff_clr),
        .sample_data        (sample_data),
        .data_ready         (data_ready),
        .fir_coefficient    (fir_coefficient),
        .new_coefficient_set(new_coefficient_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // One complete transfer: address phase, then data phase. Called and
    // returns at 1 time unit after a rising edge. coeff_clr may be asserted
    // during the data phase only.
    task automatic xfer(input logic [4:0] a, input logic w, input logic sz,
                        input logic [15:0] wd, input logic clr,
                        output logic [15:0] rdata, output logic resp);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hsize  = sz;
        hwrite = w;
        @(posedge clk); #1;
        hsel      = 1'b0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        hwdata    = wd;
        coeff_clr = clr;
        #1;
        rdata = hrdata;
        resp  = hresp;
        @(posedge clk); #1;
        coeff_clr = 1'b0;
        $display("xfer addr=0x%02h wr=%0d hw=%0d wdata=0x%04h -> rdata=0x%04h hresp=%0d",
                 a, w, sz, wd, rdata, resp);
    endtask

    initial begin
        n_rst = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 1'b0;
        hwrite = 1'b0; hwdata = '0; fir_out = 16'hFFFF; modwait = 1'b1; err = 1'b1;
        coefficient_num = 2'd0; coeff_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hrdata", hrdata, 16'h0000);
        check("rst_hresp", {15'b0, hresp}, 16'h0000);
        check("rst_sample_data", sample_data, 16'h0000);
        check("rst_data_ready", {15'b0, data_ready}, 16'h0000);
        check("rst_fir_coeff", fir_coefficient, 16'h0000);
        check("rst_ncs", {15'b0, new_coefficient_set}, 16'h0000);
        n_rst = 1'b1;
        @(posedge clk); #1;

        xfer(5'h00, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("status_after_rst", rd, 16'h0101);
        xfer(5'h02, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("result_read", rd, 16'hFFFF);
        modwait = 1'b0; err = 1'b0; fir_out = 16'h0000;

        // Coefficient 3 write and readback
        xfer(5'h16, 1'b1, 1'b1, 16'h8000, 1'b0, rd, rs);
        check("coeff3_wr_resp", {15'b0, rs}, 16'h0000);
        coefficient_num = 2'd3;
        #1;
        check("coeff3_fir_coeff", fir_coefficient, 16'h8000);
        xfer(5'h16, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("coeff3_rd", rd, 16'h8000);
        check("coeff3_rd_resp", {15'b0, rs}, 16'h0000);

        // Fill FIFO
        xfer(5'h04, 1'b1, 1'b1, 16'd1000, 1'b0, rd, rs);
        check("push1_data_ready", {15'b0, data_ready}, 16'h0001);
        xfer(5'h04, 1'b1, 1'b1, 16'd2000, 1'b0, rd, rs);
        xfer(5'h04, 1'b1, 1'b1, 16'd3000, 1'b0, rd, rs);
        xfer(5'h04, 1'b1, 1'b1, 16'd4000, 1'b0, rd, rs);
        check("push4_resp", {15'b0, rs}, 16'h0000);
        xfer(5'h08, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("count_full", rd, 16'd4);
        xfer(5'h00, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("status_full", rd, 16'h0003);
        xfer(5'h04, 1'b1, 1'b1, 16'd5000, 1'b0, rd, rs);
        check("push_full_resp", {15'b0, rs}, 16'h0001);
        xfer(5'h08, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("count_after_overflow", rd, 16'd4);
        check("head_before_pop", sample_data, 16'd1000);

        // One-cycle modwait pulse pops exactly one sample
        modwait = 1'b1;
        @(posedge clk); #1;
        modwait = 1'b0;
        #1;
        check("pop_locked_ready", {15'b0, data_ready}, 16'h0000);
        check("head_after_pop", sample_data, 16'd2000);
        @(posedge clk); #1;
        check("lock_cleared_ready", {15'b0, data_ready}, 16'h0001);
        xfer(5'h08, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("count_after_pop", rd, 16'd3);
        xfer(5'h04, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("sample_read", rd, 16'd2000);

        // Byte write to upper lane
        xfer(5'h12, 1'b1, 1'b1, 16'h1234, 1'b0, rd, rs);
        xfer(5'h13, 1'b1, 1'b0, 16'hAB00, 1'b0, rd, rs);
        check("byte_wr_resp", {15'b0, rs}, 16'h0000);
        xfer(5'h12, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("byte_wr_result", rd, 16'hAB34);
        xfer(5'h13, 1'b0, 1'b0, 16'h0, 1'b0, rd, rs);
        check("byte_rd_full", rd, 16'hAB34);
        coefficient_num = 2'd1;
        #1;
        check("coeff1_fir_coeff", fir_coefficient, 16'hAB34);

        // Error responses
        xfer(5'h02, 1'b1, 1'b1, 16'h5A5A, 1'b0, rd, rs);
        check("err_wr_result", {15'b0, rs}, 16'h0001);
        xfer(5'h05, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("err_misaligned", {15'b0, rs}, 16'h0001);
        check("err_misaligned_data", rd, 16'h0000);
        xfer(5'h1E, 1'b1, 1'b1, 16'h7777, 1'b0, rd, rs);
        check("err_unmapped", {15'b0, rs}, 16'h0001);
        xfer(5'h04, 1'b1, 1'b0, 16'h0011, 1'b0, rd, rs);
        check("err_byte_sample", {15'b0, rs}, 16'h0001);
        xfer(5'h16, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("after_err_resp", {15'b0, rs}, 16'h0000);
        check("after_err_coeff3", rd, 16'h8000);
        xfer(5'h08, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("after_err_count", rd, 16'd3);

        // Coefficient reload flag
        xfer(5'h06, 1'b1, 1'b1, 16'h0001, 1'b0, rd, rs);
        check("ncs_set", {15'b0, new_coefficient_set}, 16'h0001);
        xfer(5'h06, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("ncs_read", rd, 16'h0001);
        xfer(5'h06, 1'b1, 1'b1, 16'h0001, 1'b1, rd, rs);
        check("ncs_write_wins", {15'b0, new_coefficient_set}, 16'h0001);
        coeff_clr = 1'b1;
        @(posedge clk); #1;
        coeff_clr = 1'b0;
        check("ncs_cleared", {15'b0, new_coefficient_set}, 16'h0000);

        // Asynchronous reset during a SAMPLE write data phase
        hsel = 1'b1; htrans = 2'b10; haddr = 5'h04; hsize = 1'b1; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 16'h5555;
        n_rst = 1'b0;
        #1;
        check("midrst_data_ready", {15'b0, data_ready}, 16'h0000);
        check("midrst_sample", sample_data, 16'h0000);
        check("midrst_coeff1", fir_coefficient, 16'h0000);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        xfer(5'h08, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("midrst_count", rd, 16'd0);
        xfer(5'h16, 1'b0, 1'b1, 16'h0, 1'b0, rd, rs);
        check("midrst_coeff3", rd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
